// File: rtl/c_bus_load_unit_if.sv
// C-bus load unit port bundle: bus/control inputs from the datapath, register
// contents and status back out.
interface c_bus_load_unit_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] c_bus_in;
    logic [4:0]            load_sel;
    logic                  pc_inc;
    logic                  mem_rd_start;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] ir_out;
    logic [DATA_WIDTH-1:0] mar_out;
    logic [DATA_WIDTH-1:0] mdr_out;
    logic [DATA_WIDTH-1:0] pc_out;
    logic [DATA_WIDTH-1:0] gp_out;
    logic                  mem_busy;
    logic                  sel_error;

    modport master (
        output c_bus_in, load_sel, pc_inc, mem_rd_start, mem_ready, mem_data_in,
        input  ir_out, mar_out, mdr_out, pc_out, gp_out, mem_busy, sel_error
    );

    modport slave (
        input  c_bus_in, load_sel, pc_inc, mem_rd_start, mem_ready, mem_data_in,
        output ir_out, mar_out, mdr_out, pc_out, gp_out, mem_busy, sel_error
    );
endinterface

// File: rtl/c_bus_load_unit.sv
// Destination end of the C-bus: one-hot load into IR/MAR/MDR/PC/GP, PC
// auto-increment and a single-outstanding memory read that fills MDR.
module c_bus_load_unit #(
    parameter int unsigned          DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] PC_RESET  = '0,
    parameter int unsigned          PC_STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    c_bus_load_unit_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] PC_INC_VAL = DATA_WIDTH'(PC_STEP);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   mdr_fill;

    logic [DATA_WIDTH-1:0] ir_q;
    logic [DATA_WIDTH-1:0] mar_q;
    logic [DATA_WIDTH-1:0] mdr_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] gp_q;
    logic                  busy_q;
    logic                  sel_error_q;

    logic ld_ir;
    logic ld_mar;
    logic ld_mdr;
    logic ld_pc;
    logic ld_gp;
    logic sel_bad;

    // Load-select decode; anything that is neither one-hot nor zero is illegal
    always_comb begin
        ld_ir   = 1'b0;
        ld_mar  = 1'b0;
        ld_mdr  = 1'b0;
        ld_pc   = 1'b0;
        ld_gp   = 1'b0;
        sel_bad = 1'b0;
        case (bus.load_sel)
            5'b10000: ld_ir   = 1'b1;
            5'b01000: ld_mar  = 1'b1;
            5'b00100: ld_mdr  = 1'b1;
            5'b00010: ld_pc   = 1'b1;
            5'b00001: ld_gp   = 1'b1;
            5'b00000: ;
            default:  sel_bad = 1'b1;
        endcase
    end

    // Memory-read FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory-read FSM next state; mem_ready only matters while waiting
    always_comb begin
        state_d  = state_q;
        mdr_fill = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.mem_rd_start) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_ready) begin
                    mdr_fill = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Architectural registers and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q        <= '0;
            mar_q       <= '0;
            mdr_q       <= '0;
            pc_q        <= PC_RESET;
            gp_q        <= '0;
            busy_q      <= 1'b0;
            sel_error_q <= 1'b0;
        end else begin
            busy_q <= (state_d == ST_WAIT);
            if (sel_bad) begin
                sel_error_q <= 1'b1;
            end
            if (ld_ir) begin
                ir_q <= bus.c_bus_in;
            end
            if (ld_mar) begin
                mar_q <= bus.c_bus_in;
            end
            if (ld_gp) begin
                gp_q <= bus.c_bus_in;
            end
            // Bus load to MDR is dropped while a read owns it
            if (mdr_fill) begin
                mdr_q <= bus.mem_data_in;
            end else if (ld_mdr && (state_q == ST_IDLE)) begin
                mdr_q <= bus.c_bus_in;
            end
            if (ld_pc) begin
                pc_q <= bus.c_bus_in;
            end else if (bus.pc_inc) begin
                pc_q <= pc_q + PC_INC_VAL;
            end
        end
    end

    assign bus.ir_out    = ir_q;
    assign bus.mar_out   = mar_q;
    assign bus.mdr_out   = mdr_q;
    assign bus.pc_out    = pc_q;
    assign bus.gp_out    = gp_q;
    assign bus.mem_busy  = busy_q;
    assign bus.sel_error = sel_error_q;
endmodule

// File: tb/tb_c_bus_load_unit.sv
// Scoreboard bench for c_bus_load_unit: stimulus pushes the reference model's
// expected post-edge state, a monitor pops and compares after each edge.
module tb_c_bus_load_unit;
    localparam int unsigned   DW       = 16;
    localparam logic [DW-1:0] PC_RST_V = 16'h0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    c_bus_load_unit_if #(.DATA_WIDTH(DW)) bif ();

    c_bus_load_unit #(
        .DATA_WIDTH(DW),
        .PC_RESET  (PC_RST_V),
        .PC_STEP   (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    typedef struct packed {
        logic [DW-1:0] ir;
        logic [DW-1:0] mar;
        logic [DW-1:0] mdr;
        logic [DW-1:0] pc;
        logic [DW-1:0] gp;
        logic          busy;
        logic          err;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: m_reg index 0..4 = IR, MAR, MDR, PC, GP
    logic [DW-1:0] m_reg [5];
    logic          m_busy;
    logic          m_err;

    task automatic cmp(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, queue the expectation
    task automatic step(input logic rst, input logic [4:0] sel, input logic [DW-1:0] d,
                        input logic inc, input logic st, input logic rdy,
                        input logic [DW-1:0] md);
        int   n;
        logic was_busy;
        exp_t e;
        reset            = rst;
        bif.load_sel     = sel;
        bif.c_bus_in     = d;
        bif.pc_inc       = inc;
        bif.mem_rd_start = st;
        bif.mem_ready    = rdy;
        bif.mem_data_in  = md;
        if (rst) begin
            for (int i = 0; i < 5; i++) m_reg[i] = '0;
            m_reg[3] = PC_RST_V;
            m_busy   = 1'b0;
            m_err    = 1'b0;
        end else begin
            n        = $countones(sel);
            was_busy = m_busy;
            if (n > 1) begin
                m_err = 1'b1;
            end else if (n == 1) begin
                for (int i = 0; i < 5; i++) begin
                    if (sel[4-i] && !(i == 2 && was_busy)) m_reg[i] = d;
                end
            end
            if (inc && sel != 5'b00010) m_reg[3] = DW'(m_reg[3] + 1);
            if (was_busy) begin
                if (rdy) begin
                    m_reg[2] = md;
                    m_busy   = 1'b0;
                end
            end else if (st) begin
                m_busy = 1'b1;
            end
        end
        e = '{ir: m_reg[0], mar: m_reg[1], mdr: m_reg[2], pc: m_reg[3], gp: m_reg[4],
              busy: m_busy, err: m_err};
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every output is presented each cycle, checked just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("ir_out",    bif.ir_out,  e.ir);
                cmp("mar_out",   bif.mar_out, e.mar);
                cmp("mdr_out",   bif.mdr_out, e.mdr);
                cmp("pc_out",    bif.pc_out,  e.pc);
                cmp("gp_out",    bif.gp_out,  e.gp);
                cmp("mem_busy",  DW'(bif.mem_busy),  DW'(e.busy));
                cmp("sel_error", DW'(bif.sel_error), DW'(e.err));
            end
        end
    end

    initial begin
        logic [4:0] sel;
        logic [4:0] legal_codes [6];
        legal_codes[0] = 5'b10000; legal_codes[1] = 5'b01000; legal_codes[2] = 5'b00100;
        legal_codes[3] = 5'b00010; legal_codes[4] = 5'b00001; legal_codes[5] = 5'b00000;

        step(1'b1, 5'b00000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 5'b00000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        // Load each register, then hold
        step(1'b0, 5'b10000, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 5'b01000, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 5'b00100, 16'h5678, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 5'b00010, 16'h9ABC, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 5'b00001, 16'hDEF0, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (3) step(1'b0, 5'b00000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000);
        // PC wrap, then load beats increment
        step(1'b0, 5'b00010, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (3) step(1'b0, 5'b00000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 5'b00010, 16'h0100, 1'b1, 1'b0, 1'b0, 16'h0000);
        // Illegal select is sticky until reset
        step(1'b0, 5'b00011, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 5'b00001, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 5'b10000, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 5'b00000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        // Read: MDR bus load and a second start during WAIT are ignored
        step(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 5'b00100, 16'h7777, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 5'b01000, 16'h4444, 1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        step(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hDEAD);
        // mem_ready in the same cycle as the start is ignored
        step(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1357);
        step(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        // Reset in WAIT with mem_ready on the same edge
        step(1'b1, 5'b00000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hCAFE);
        step(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 8) sel = legal_codes[$urandom_range(0, 5)];
            else                          sel = 5'($urandom);
            step(($urandom_range(0, 59) == 0), sel, 16'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0), 16'($urandom));
        end

        reset = 1'b0;
        bif.load_sel = 5'b00000; bif.pc_inc = 1'b0;
        bif.mem_rd_start = 1'b0; bif.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
